// File: rtl/rr_mux_pkg.sv
// Shared definitions for the rr_mux channel merger and its arbitration helper.
package rr_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Index width for v items; never below 1 so single-bit selects stay legal.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Producer/consumer handshake bundle for rr_mux; slave is the mux side.
interface rr_mux_if
    import rr_mux_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  s;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;

    modport master (
        output in_valid, in_data, mode, s, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, mode, s, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_mux_pick.sv
// Combinational rotating-priority picker: first set req at or after ptr, wrapping.
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Two ordered passes (indices >= ptr, then < ptr) avoid modular index arithmetic.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[i] && (SW'(i) >= ptr)) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[i] && (SW'(i) < ptr)) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel flow-controlled merger with round-robin or fixed-select grant and a
// registered output stage that drains and refills in the same cycle.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input logic    clk,
    input logic    rst,
    rr_mux_if.slave bus
);
    localparam int unsigned SW = clog2(N);
    localparam int unsigned NP = 1 << SW;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic          state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] ch_q, ch_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] rr_idx, gnt_idx;
    logic          rr_any, gnt_any;
    logic [NP-1:0] valid_ext;
    logic [W-1:0]  sel_data;
    logic          accept, take;

    rr_pick #(
        .N (N),
        .SW(SW)
    ) u_pick (
        .req    (bus.in_valid),
        .ptr    (ptr_q),
        .gnt_idx(rr_idx),
        .gnt_any(rr_any)
    );

    // Padding to a power of two makes out-of-range s read a zero valid bit.
    assign valid_ext = NP'(bus.in_valid);

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (bus.mode == MODE_RR) begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
        end else if (valid_ext[bus.s]) begin
            gnt_any = 1'b1;
            gnt_idx = bus.s;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) sel_data = bus.in_data[i*W +: W];
        end
    end

    assign accept       = (state_q == ST_EMPTY) || bus.out_ready;
    assign take         = gnt_any && accept && !rst;
    assign bus.in_ready = take ? (N'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (take) begin
            state_d = ST_FULL;
            data_d  = sel_data;
            ch_d    = gnt_idx;
            if (bus.mode == MODE_RR) begin
                ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
            end
        end else if (bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a 4-channel instance for most scenarios and a
// 3-channel instance for out-of-range select and pointer wrap.
module tb_rr_mux;
    import rr_mux_pkg::*;

    logic clk;
    logic rst_a, rst_b;
    int   total, bad;

    rr_mux_if #(.N(4), .W(8)) bus_a ();
    rr_mux_if #(.N(3), .W(8)) bus_b ();

    rr_mux #(.N(4), .W(8)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    rr_mux #(.N(3), .W(8)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus_a.in_valid  = 4'b1111;
        bus_a.in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        bus_a.mode      = MODE_RR;
        bus_a.s         = '0;
        bus_a.out_ready = 1'b1;
        rst_a = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (bus_a.in_ready !== 4'b0000) begin
                bad++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0000", c, bus_a.in_ready);
            end
            total++;
            if (bus_a.out_valid !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, bus_a.out_valid);
            end
            total++;
            if (bus_a.out_data !== 8'h00) begin
                bad++; $display("FAIL reset_out_data cyc=%0d got=%h exp=00", c, bus_a.out_data);
            end
        end
        rst_a = 1'b0;
        #1;
        total++;
        if (bus_a.in_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_first_grant got=%b exp=0001", bus_a.in_ready);
        end
    endtask

    task automatic test_rr_all();
        logic [7:0] exp_data [4];
        exp_data[0] = 8'h10; exp_data[1] = 8'h21; exp_data[2] = 8'h32; exp_data[3] = 8'h43;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus_a.in_ready !== (4'b0001 << (k % 4))) begin
                bad++; $display("FAIL rr_in_ready k=%0d got=%b", k, bus_a.in_ready);
            end
            tick();
            total++;
            if (bus_a.out_ch !== 2'(k % 4) || bus_a.out_data !== exp_data[k % 4] ||
                bus_a.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_out k=%0d got ch=%0d data=%h v=%b exp ch=%0d data=%h v=1",
                         k, bus_a.out_ch, bus_a.out_data, bus_a.out_valid, k % 4, exp_data[k % 4]);
            end
        end
    endtask

    task automatic test_wrap();
        reset_a();
        bus_a.in_valid = 4'b0010;
        tick();  // ch1 transfers, ptr becomes 2
        bus_a.in_valid = 4'b1010;
        #1;
        total++;
        if (bus_a.in_ready !== 4'b1000) begin
            bad++; $display("FAIL wrap_first got=%b exp=1000", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_ch !== 2'd3 || bus_a.out_data !== 8'h43) begin
            bad++; $display("FAIL wrap_out3 got ch=%0d data=%h exp ch=3 data=43", bus_a.out_ch, bus_a.out_data);
        end
        total++;
        if (bus_a.in_ready !== 4'b0010) begin
            bad++; $display("FAIL wrap_second got=%b exp=0010", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_ch !== 2'd1 || bus_a.out_data !== 8'h21) begin
            bad++; $display("FAIL wrap_out1 got ch=%0d data=%h exp ch=1 data=21", bus_a.out_ch, bus_a.out_data);
        end
        total++;
        if (bus_a.in_ready !== 4'b1000) begin
            bad++; $display("FAIL wrap_third got=%b exp=1000", bus_a.in_ready);
        end
    endtask

    task automatic test_backpressure();
        reset_a();
        bus_a.in_valid = 4'b0001;
        bus_a.in_data  = {8'h43, 8'h32, 8'h21, 8'h55};
        tick();
        bus_a.in_data   = {8'h43, 8'h32, 8'h21, 8'h66};
        bus_a.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus_a.in_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0000", c, bus_a.in_ready);
            end
            tick();
            total++;
            if (bus_a.out_data !== 8'h55 || bus_a.out_valid !== 1'b1 || bus_a.out_ch !== 2'd0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got data=%h v=%b ch=%0d exp data=55 v=1 ch=0",
                                c, bus_a.out_data, bus_a.out_valid, bus_a.out_ch);
            end
        end
        bus_a.out_ready = 1'b1;
        #1;
        total++;
        if (bus_a.in_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_release_ready got=%b exp=0001", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_data !== 8'h66 || bus_a.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_refill got data=%h v=%b exp data=66 v=1", bus_a.out_data, bus_a.out_valid);
        end
    endtask

    task automatic test_midreset();
        rst_a = 1'b1;
        #1;
        total++;
        if (bus_a.in_ready !== 4'b0000) begin
            bad++; $display("FAIL midrst_in_ready got=%b exp=0000", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'h00) begin
            bad++; $display("FAIL midrst_out got v=%b data=%h exp v=0 data=00", bus_a.out_valid, bus_a.out_data);
        end
        rst_a = 1'b0;
    endtask

    task automatic test_fixed();
        reset_a();
        bus_a.mode     = MODE_FIXED;
        bus_a.s        = 2'd2;
        bus_a.in_valid = 4'b1111;
        bus_a.in_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus_a.in_ready !== 4'b0100) begin
                bad++; $display("FAIL fixed_ready cyc=%0d got=%b exp=0100", c, bus_a.in_ready);
            end
            tick();
            total++;
            if (bus_a.out_data !== 8'hA5 || bus_a.out_ch !== 2'd2 || bus_a.out_valid !== 1'b1) begin
                bad++; $display("FAIL fixed_out cyc=%0d got data=%h ch=%0d v=%b exp data=a5 ch=2 v=1",
                                c, bus_a.out_data, bus_a.out_ch, bus_a.out_valid);
            end
        end
        bus_a.in_valid  = 4'b1011;
        bus_a.out_ready = 1'b0;
        #1;
        total++;
        if (bus_a.in_ready !== 4'b0000) begin
            bad++; $display("FAIL fixed_nogrant got=%b exp=0000", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_valid !== 1'b1) begin
            bad++; $display("FAIL fixed_hold got v=%b exp=1", bus_a.out_valid);
        end
        bus_a.out_ready = 1'b1;
        tick();
        total++;
        if (bus_a.out_valid !== 1'b0) begin
            bad++; $display("FAIL fixed_drain got v=%b exp=0", bus_a.out_valid);
        end
        // ptr stayed at 0 through the fixed-mode transfers.
        bus_a.mode     = MODE_RR;
        bus_a.in_valid = 4'b1111;
        #1;
        total++;
        if (bus_a.in_ready !== 4'b0001) begin
            bad++; $display("FAIL fixed_ptr_kept got=%b exp=0001", bus_a.in_ready);
        end
    endtask

    task automatic test_n3();
        bus_b.in_valid  = 3'b111;
        bus_b.in_data   = {8'hC2, 8'hB1, 8'hA0};
        bus_b.mode      = MODE_FIXED;
        bus_b.s         = 2'd3;
        bus_b.out_ready = 1'b1;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        #1;
        total++;
        if (bus_b.in_ready !== 3'b000) begin
            bad++; $display("FAIL n3_s3_ready got=%b exp=000", bus_b.in_ready);
        end
        tick();
        total++;
        if (bus_b.out_valid !== 1'b0) begin
            bad++; $display("FAIL n3_s3_valid got=%b exp=0", bus_b.out_valid);
        end
        bus_b.mode     = MODE_RR;
        bus_b.in_valid = 3'b100;
        #1;
        total++;
        if (bus_b.in_ready !== 3'b100) begin
            bad++; $display("FAIL n3_ch2_ready got=%b exp=100", bus_b.in_ready);
        end
        tick();
        total++;
        if (bus_b.out_ch !== 2'd2 || bus_b.out_data !== 8'hC2) begin
            bad++; $display("FAIL n3_ch2_out got ch=%0d data=%h exp ch=2 data=c2", bus_b.out_ch, bus_b.out_data);
        end
        bus_b.in_valid = 3'b111;
        #1;
        total++;
        if (bus_b.in_ready !== 3'b001) begin
            bad++; $display("FAIL n3_wrap_ready got=%b exp=001", bus_b.in_ready);
        end
        tick();
        total++;
        if (bus_b.out_ch !== 2'd0 || bus_b.out_data !== 8'hA0) begin
            bad++; $display("FAIL n3_wrap_out got ch=%0d data=%h exp ch=0 data=a0", bus_b.out_ch, bus_b.out_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_b.in_valid  = '0;
        bus_b.in_data   = '0;
        bus_b.mode      = MODE_RR;
        bus_b.s         = '0;
        bus_b.out_ready = 1'b1;
        test_reset();
        tick();  // channel 0 from the release cycle lands here
        total++;
        if (bus_a.out_ch !== 2'd0 || bus_a.out_data !== 8'h10 || bus_a.out_valid !== 1'b1) begin
            bad++; $display("FAIL first_beat got ch=%0d data=%h v=%b exp ch=0 data=10 v=1",
                            bus_a.out_ch, bus_a.out_data, bus_a.out_valid);
        end
        reset_a();
        test_rr_all();
        test_wrap();
        test_backpressure();
        test_midreset();
        test_fixed();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
